// File: rtl/apb_pkg.sv
// Shared definitions for the APB completer register bank: bus widths, FSM states,
// register indices and the ID constant.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 16;
    localparam int unsigned APB_DATA_W = 32;
    localparam int unsigned MAX_REGS   = 16;
    localparam int unsigned WAIT_W     = 4;

    localparam logic [31:0] APB_ID_VALUE = 32'hA5B0_0001;

    localparam logic [3:0] REG_ID   = 4'd0;
    localparam logic [3:0] REG_WAIT = 4'd1;
    localparam logic [3:0] REG_CTRL = 4'd2;

    typedef enum logic {
        IDLE,
        ACCESS
    } apb_state_e;

endpackage

// File: rtl/apb_wait_gen.sv
// Loadable down-counter that stretches the ACCESS phase by a programmed number of
// wait states; done is high once the count has reached zero.
module apb_wait_gen
    import apb_pkg::*;
#(
    parameter int unsigned WIDTH = WAIT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             done
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/apb_slave_regbank.sv
// APB3 completer with a word-addressed register bank, programmable wait states and
// error response for misaligned, out-of-range or read-only accesses.
module apb_slave_regbank
    import apb_pkg::*;
#(
    parameter int unsigned         ADDR_W   = APB_ADDR_W,
    parameter int unsigned         DATA_W   = APB_DATA_W,
    parameter int unsigned         NUM_REGS = MAX_REGS,
    parameter logic [DATA_W-1:0]   ID_VALUE = APB_ID_VALUE,
    parameter logic [WAIT_W-1:0]   WAIT_RST = '0
) (
    input  logic              pclk_i,
    input  logic              prst_n_i,
    input  logic [ADDR_W-1:0] paddr_i,
    input  logic              pwrite_i,
    input  logic              psel_i,
    input  logic              penable_i,
    input  logic [DATA_W-1:0] pwdata_i,
    output logic [DATA_W-1:0] prdata_o,
    output logic              pready_o,
    output logic              pslverr_o,
    output logic [DATA_W-1:0] ctrl_o
);

    apb_state_e state, state_next;

    logic [3:0]        idx_in;
    logic              err_in;
    logic [3:0]        idx_q;
    logic              write_q;
    logic              err_q;
    logic [DATA_W-1:0] wdata_q;

    logic [WAIT_W-1:0] wait_cfg;
    logic [DATA_W-1:0] regs [MAX_REGS];
    logic [DATA_W-1:0] rd_val;

    logic load, dec, done, ready, commit;

    assign idx_in = paddr_i[5:2];
    assign err_in = (paddr_i[1:0] != 2'b00)
                 || ({1'b0, idx_in} >= 5'(NUM_REGS))
                 || (paddr_i[ADDR_W-1:6] != '0)
                 || (pwrite_i && (idx_in == REG_ID));

    apb_wait_gen #(
        .WIDTH (WAIT_W)
    ) u_wait_gen (
        .clk      (pclk_i),
        .rst_n    (prst_n_i),
        .load     (load),
        .load_val (wait_cfg),
        .dec      (dec),
        .done     (done)
    );

    always_comb begin
        state_next = state;
        load       = 1'b0;
        dec        = 1'b0;
        ready      = 1'b0;
        unique case (state)
            IDLE: begin
                if (psel_i && !penable_i) begin
                    state_next = ACCESS;
                    load       = 1'b1;
                end
            end
            ACCESS: begin
                if (psel_i && penable_i) begin
                    if (done) begin
                        ready      = 1'b1;
                        state_next = IDLE;
                    end else begin
                        dec = 1'b1;
                    end
                end else begin
                    // Master dropped the handshake: abandon the transfer silently.
                    state_next = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        rd_val = regs[idx_q];
        if (idx_q == REG_ID) begin
            rd_val = ID_VALUE;
        end else if (idx_q == REG_WAIT) begin
            rd_val = DATA_W'(wait_cfg);
        end
    end

    assign commit = ready && !err_q && write_q;

    always_ff @(posedge pclk_i) begin
        if (!prst_n_i) begin
            state    <= IDLE;
            idx_q    <= '0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            wait_cfg <= WAIT_RST;
            for (int i = 0; i < int'(MAX_REGS); i++) begin
                regs[i] <= '0;
            end
        end else begin
            state <= state_next;
            if (load) begin
                idx_q   <= idx_in;
                write_q <= pwrite_i;
                err_q   <= err_in;
                wdata_q <= pwdata_i;
            end
            if (commit) begin
                if (idx_q == REG_WAIT) begin
                    wait_cfg <= wdata_q[WAIT_W-1:0];
                end else begin
                    regs[idx_q] <= wdata_q;
                end
            end
        end
    end

    assign pready_o  = ready;
    assign pslverr_o = ready && err_q;
    assign prdata_o  = (ready && !err_q && !write_q) ? rd_val : '0;
    assign ctrl_o    = regs[REG_CTRL];

endmodule
